execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 16-bit pipelined CPU. It consumes the instruction bundle held in the decode/execute pipeline register, evaluates the ALU operation, and passes the registered result, status flags and downstream control bits toward the execute/memory boundary. Single-cycle operations complete with a one-cycle latency. Multiply is an iterative shift-add operation, and the stage back-pressures the decode/execute register with `stall_out` while the multiply runs.

## Interface
- `WIDTH`, 16, datapath width. Shift amount uses `srcB_in[3:0]`.
- `MUL_CYCLES`, 16, BUSY iterations for multiply. Must equal `WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `valid_in`  in  1  the decode/execute register holds a live instruction.
- `flush_in`  in  1  synchronous kill of the current or in-flight instruction.
- `ALUop_in`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 SHR.
- `srcA_in`, `srcB_in`  in  16 each  operands.
- `wbs_in`, `mm_in`, `wm_in`, `wce_in`, `wme1_in`, `wme2_in`  in  1 each  downstream control bits.
- `stall_out`  out  1  hold the decode/execute register.
- `valid_out`  out  1  result bundle is valid this cycle.
- `result_out`  out  16  ALU result.
- `zero_out`, `neg_out`  out  1 each  `result_out == 0`, `result_out[15]`.
- `wbs_out`, `mm_out`, `wm_out`, `wce_out`, `wme1_out`, `wme2_out`  out  1 each  registered copies of the control bits.

## Operation
- FSM states:
  - IDLE: accepts instructions.
  - BUSY: multiply iterations.
  - DONE: multiply result presented.
- Accept condition: IDLE && `valid_in` && !`flush_in`.
- Accepting a non-MUL op:
  - Compute the result combinationally and register it with the flags and control bits.
  - `valid_out` = 1 next cycle.
  - State stays IDLE.
- Accepting a MUL:
  - Latch `srcA`, `srcB` and the control bits.
  - Clear the accumulator and load the counter with `MUL_CYCLES-1`.
  - Go to BUSY.
- BUSY, each cycle:
  - If multiplier LSB = 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right.
  - Decrement the counter; when the counter = 0, go to DONE.
- DONE:
  - `result_out` = accumulator, with `valid_out` = 1 and the latched control bits.
  - `valid_in` is ignored, because the held MUL is still presented on the inputs.
  - Next state is IDLE.
- `stall_out` = (IDLE && `valid_in` && `ALUop_in`==110 && !`flush_in`) || BUSY. It is combinational and low in DONE.
- Arithmetic:
  - ADD and SUB wrap modulo 2^16.
  - SHL and SHR are logical shifts by `srcB[3:0]`.
  - MUL returns the low 16 bits of the product.
- When `valid_out` = 0, `result_out`, the flags and all control outputs are 0.
- `flush_in`:
  - In IDLE it suppresses acceptance.
  - In BUSY or DONE it forces IDLE next cycle with `valid_out` = 0, and `stall_out` drops in the flush cycle.
- Priority: `rst` > `flush_in` > normal operation.
- `rst` mid-multiply: the FSM returns to IDLE and the accumulator and counter clear. No result is emitted.

## Timing
- Reset values: state IDLE, every output 0, including `stall_out`, because it is combinational and its terms are false after reset with `valid_in` = 0.
- Single-cycle op sampled in cycle N: outputs valid in cycle N+1 for exactly 1 cycle.
- Back-to-back single-cycle ops: one result per cycle, no bubbles.
- MUL sampled in cycle N:
  - `stall_out` is high in cycles N through N+16 (17 cycles).
  - BUSY covers N+1 through N+16.
  - DONE is cycle N+17, with `valid_out` high for one cycle and `stall_out` low.
  - The stage returns to IDLE at N+18 and accepts the next instruction, which the decode/execute register loads at the end of N+17.
- `valid_in` = 0 in IDLE: `valid_out` is 0 next cycle and all outputs are zeroed.

## Test plan
- Reset: assert `rst` for 2 cycles with `valid_in` = 1, ADD -> all outputs 0 through reset and on the first cycle after release.
- ADD 0x0006 + 0x0007 with `wbs`=1 and `mm`=1, then SUB 0x0001 − 0x0005 back-to-back:
  - Next cycle: 0x000D, `zero`=0, `wbs_out`=1, `mm_out`=1.
  - Following cycle: 0xFFFC, `neg`=1.
  - No bubble between the two results.
- Logic and shifts, each checked one cycle after its input:
  - AND 0x00F0, 0x0F0F -> 0x0000, `zero`=1.
  - SHL 0x0001 by 0x0013 -> 0x0008 (shift amount 3).
  - SHR 0x8000 by 4 -> 0x0800.
- MUL 0x0006 × 0x0007 held while stalled:
  - `stall_out` high for exactly 17 cycles.
  - `valid_out` only at N+17 with 0x002A.
  - The following ADD result appears at N+19.
- MUL 0x1234 × 0x0100 -> 0x3400 (truncation). MUL 0xFFFF × 0xFFFF -> 0x0001.
- Abort cases:
  - `flush_in` at N+5 during MUL: `stall_out` low at N+5, no `valid_out` afterward, next ADD accepted at N+6.
  - Repeat with `rst` at N+5: same result.

Source files
------------

// File: rtl/execute_if.sv
// execute_if: decode/execute bundle into the execute stage and result bundle out of it
interface execute_if #(parameter int WIDTH = 16);
  logic             valid_in;
  logic             flush_in;
  logic [2:0]       ALUop_in;
  logic [WIDTH-1:0] srcA_in;
  logic [WIDTH-1:0] srcB_in;
  logic             wbs_in, mm_in, wm_in, wce_in, wme1_in, wme2_in;
  logic             stall_out;
  logic             valid_out;
  logic [WIDTH-1:0] result_out;
  logic             zero_out, neg_out;
  logic             wbs_out, mm_out, wm_out, wce_out, wme1_out, wme2_out;
  modport master (
    output valid_in, flush_in, ALUop_in, srcA_in, srcB_in,
           wbs_in, mm_in, wm_in, wce_in, wme1_in, wme2_in,
    input  stall_out, valid_out, result_out, zero_out, neg_out,
           wbs_out, mm_out, wm_out, wce_out, wme1_out, wme2_out
  );
  modport slave (
    input  valid_in, flush_in, ALUop_in, srcA_in, srcB_in,
           wbs_in, mm_in, wm_in, wce_in, wme1_in, wme2_in,
    output stall_out, valid_out, result_out, zero_out, neg_out,
           wbs_out, mm_out, wm_out, wce_out, wme1_out, wme2_out
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU plus iterative shift-add multiply with pipeline stall
module execute_stage #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input logic      clk,
  input logic      rst,
  execute_if.slave bus
);
  localparam int CW = $clog2(MUL_CYCLES);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] alu, res_q, mcand, mplier, acc, result;
  logic [CW-1:0]    cnt;
  logic [5:0]       ctl_in, ctl_q, mctl;
  logic             vld_q, is_mul, accept, done, valid;
  assign ctl_in = {bus.wbs_in, bus.mm_in, bus.wm_in, bus.wce_in, bus.wme1_in, bus.wme2_in};
  assign is_mul = bus.ALUop_in == 3'b110;
  assign accept = state == IDLE && bus.valid_in && !bus.flush_in;
  assign done   = state == DONE;
  // single-cycle ALU result; MUL never goes through this path
  always_comb begin
    alu = bus.ALUop_in == 3'b000 ? bus.srcA_in + bus.srcB_in :
          bus.ALUop_in == 3'b001 ? bus.srcA_in - bus.srcB_in :
          bus.ALUop_in == 3'b010 ? bus.srcA_in & bus.srcB_in :
          bus.ALUop_in == 3'b011 ? bus.srcA_in | bus.srcB_in :
          bus.ALUop_in == 3'b100 ? bus.srcA_in ^ bus.srcB_in :
          bus.ALUop_in == 3'b101 ? bus.srcA_in << bus.srcB_in[SW-1:0] :
          bus.ALUop_in == 3'b111 ? bus.srcA_in >> bus.srcB_in[SW-1:0] : '0;
  end
  // next state: a flush aborts a multiply in flight, DONE always lasts one cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept && is_mul ? BUSY : IDLE;
      BUSY:    state_n = bus.flush_in ? IDLE : cnt == '0 ? DONE : BUSY;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // result bundle for single-cycle ops; zeroed whenever nothing was accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
      ctl_q <= '0;
    end else begin
      vld_q <= accept && !is_mul;
      res_q <= accept && !is_mul ? alu : '0;
      ctl_q <= accept && !is_mul ? ctl_in : '0;
    end
  end
  // shift-add multiplier: one multiplier bit per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mctl   <= '0;
    end else if (accept && is_mul) begin
      mcand  <= bus.srcA_in;
      mplier <= bus.srcB_in;
      acc    <= '0;
      cnt    <= CW'(MUL_CYCLES - 1);
      mctl   <= ctl_in;
    end else if (state == BUSY) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
  assign valid  = vld_q || done;
  assign result = done ? acc : res_q;
  assign bus.stall_out  = !rst && !bus.flush_in &&
                          ((state == IDLE && bus.valid_in && is_mul) || state == BUSY);
  assign bus.valid_out  = valid;
  assign bus.result_out = result;
  assign bus.zero_out   = valid && result == '0;
  assign bus.neg_out    = result[WIDTH-1];
  assign {bus.wbs_out, bus.mm_out, bus.wm_out, bus.wce_out, bus.wme1_out, bus.wme2_out} =
         done ? mctl : ctl_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table plus multiply/abort sequences for execute_stage
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  execute_if #(.WIDTH(16)) bus();
  execute_stage #(.WIDTH(16), .MUL_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  c;
    logic [15:0] r;
    logic        z;
    logic        n;
  } vec_t;
  vec_t vt [8];
  int n_chk = 0;
  int n_fail = 0;
  logic [5:0] ctl_o;
  assign ctl_o = {bus.wbs_out, bus.mm_out, bus.wm_out, bus.wce_out, bus.wme1_out, bus.wme2_out};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input logic v, input logic [15:0] r,
                         input logic z, input logic n, input logic [5:0] c);
    chk({name, "_valid"}, 32'(bus.valid_out), 32'(v));
    chk({name, "_result"}, 32'(bus.result_out), 32'(r));
    chk({name, "_zero"}, 32'(bus.zero_out), 32'(z));
    chk({name, "_neg"}, 32'(bus.neg_out), 32'(n));
    chk({name, "_ctl"}, 32'(ctl_o), 32'(c));
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [5:0] c);
    bus.valid_in = v;
    bus.ALUop_in = op;
    bus.srcA_in  = a;
    bus.srcB_in  = b;
    {bus.wbs_in, bus.mm_in, bus.wm_in, bus.wce_in, bus.wme1_in, bus.wme2_in} = c;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input logic [5:0] c);
    int stalls;
    int at;
    stalls = 0;
    at = -1;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 6'h0);
    tick();
    drive(1'b1, 3'd6, a, b, c);
    for (int k = 0; k < 40 && at < 0; k++) begin
      @(negedge clk);
      if (bus.stall_out) stalls++;
      if (bus.valid_out) begin
        at = k;
        chk("mul_result", 32'(bus.result_out), 32'(exp));
        chk("mul_ctl", 32'(ctl_o), 32'(c));
        chk("mul_done_stall", 32'(bus.stall_out), 32'd0);
      end else begin
        tick();
      end
    end
    chk("mul_latency", at, 32'd17);
    chk("mul_stall_cycles", stalls, 32'd17);
    tick();
    drive(1'b1, 3'd0, 16'h0002, 16'h0003, 6'h0);
    @(negedge clk);
    chk("post_mul_idle_valid", 32'(bus.valid_out), 32'd0);
    chk("post_mul_idle_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk_out("post_mul_add", 1'b1, 16'h0005, 1'b0, 1'b0, 6'h0);
    drive(1'b0, 3'd0, 16'h0, 16'h0, 6'h0);
  endtask
  task automatic run_abort(input logic use_rst);
    int seen;
    seen = 0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 6'h0);
    tick();
    drive(1'b1, 3'd6, 16'h0006, 16'h0007, 6'b111111);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_pre_stall", 32'(bus.stall_out), 32'd1);
      tick();
    end
    if (use_rst) rst = 1'b1;
    else bus.flush_in = 1'b1;
    @(negedge clk);
    chk("abort_stall_drop", 32'(bus.stall_out), 32'd0);
    chk("abort_valid", 32'(bus.valid_out), 32'd0);
    tick();
    rst = 1'b0;
    bus.flush_in = 1'b0;
    drive(1'b1, 3'd0, 16'h0004, 16'h0005, 6'b100000);
    @(negedge clk);
    chk("abort_next_valid", 32'(bus.valid_out), 32'd0);
    chk("abort_next_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk_out("abort_add", 1'b1, 16'h0009, 1'b0, 1'b0, 6'b100000);
    drive(1'b0, 3'd0, 16'h0, 16'h0, 6'h0);
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.valid_out) seen++;
    end
    chk("abort_no_result", seen, 32'd0);
  endtask
  initial begin
    vt[0] = '{3'd0, 16'h0006, 16'h0007, 6'b110000, 16'h000D, 1'b0, 1'b0};
    vt[1] = '{3'd1, 16'h0001, 16'h0005, 6'b000000, 16'hFFFC, 1'b0, 1'b1};
    vt[2] = '{3'd2, 16'h00F0, 16'h0F0F, 6'b001000, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{3'd5, 16'h0001, 16'h0013, 6'b000100, 16'h0008, 1'b0, 1'b0};
    vt[4] = '{3'd7, 16'h8000, 16'h0004, 6'b000010, 16'h0800, 1'b0, 1'b0};
    vt[5] = '{3'd3, 16'h1200, 16'h0034, 6'b000001, 16'h1234, 1'b0, 1'b0};
    vt[6] = '{3'd4, 16'hFFFF, 16'h00FF, 6'b111111, 16'hFF00, 1'b0, 1'b1};
    vt[7] = '{3'd0, 16'hFFFF, 16'h0001, 6'b000000, 16'h0000, 1'b1, 1'b0};
    bus.flush_in = 1'b0;
    rst = 1'b1;
    drive(1'b1, 3'd0, 16'h0006, 16'h0007, 6'b111111);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_out("reset", 1'b0, 16'h0, 1'b0, 1'b0, 6'h0);
      chk("reset_stall", 32'(bus.stall_out), 32'd0);
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 6'h0);
    tick();
    chk_out("post_reset", 1'b0, 16'h0, 1'b0, 1'b0, 6'h0);
    chk("post_reset_stall", 32'(bus.stall_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].c);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall_out), 32'd0);
      tick();
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].r, vt[i].z, vt[i].n, vt[i].c);
    end
    drive(1'b0, 3'd0, 16'h1111, 16'h2222, 6'b111111);
    tick();
    chk_out("bubble", 1'b0, 16'h0, 1'b0, 1'b0, 6'h0);
    run_mul(16'h0006, 16'h0007, 16'h002A, 6'b101010);
    run_mul(16'h1234, 16'h0100, 16'h3400, 6'b010101);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 6'b000000);
    run_abort(1'b0);
    run_abort(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
